// File: rtl/ap_pkg.sv
// Shared types for the associative-processor sequencer.
//   ap_op_e     : AP operation codes as seen on the cmd / ap_cmd buses
//   COL_A/B/C   : AP column select values (operand A, operand B, result C)
//   seq_state_e : sequencer FSM states
package ap_pkg;

  typedef enum logic [2:0] {
    OP_OR   = 3'd0,
    OP_XOR  = 3'd1,
    OP_AND  = 3'd2,
    OP_NOT  = 3'd3,
    OP_ADD  = 3'd4,
    OP_SUB  = 3'd5,
    OP_MULT = 3'd6
  } ap_op_e;

  localparam logic [1:0] COL_A = 2'd0;
  localparam logic [1:0] COL_B = 2'd1;
  localparam logic [1:0] COL_C = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR0,
    S_CLR1,
    S_LOAD_A,
    S_LOAD_B,
    S_COMPUTE,
    S_RD_REQ,
    S_RD_WAIT,
    S_RD_HOLD,
    S_FIN
  } seq_state_e;

endpackage

// File: rtl/ap_irq_edge.sv
// Registers the AP completion interrupt and emits a one-cycle registered
// pulse on its rising edge.
//   clk_i  : clock
//   rst_ni : async active-low reset
//   irq_i  : raw ap_state_irq level from the AP
//   rise_o : one-cycle pulse, high the cycle after irq_i first seen high
module ap_irq_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic irq_i,
  output logic rise_o
);

  logic irq_q;
  logic rise_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      irq_q  <= irq_i;
      rise_q <= irq_i & ~irq_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/ap_sequencer.sv
// Runs one complete AP job: clear both internal banks, stream CELL_QUANT
// words into column A (and column B unless NOT), launch the operation, wait
// for the AP interrupt, then stream the CELL_QUANT column-C results out.
//   CLK100MHZ, rst_n           : clock, async active-low reset
//   start, cmd, op_direction   : job request with latched op code/direction
//   abort                      : synchronous job cancel
//   busy, done, timeout_err    : job status
//   in_valid/in_ready/in_data  : operand stream (valid/ready)
//   out_valid/out_ready/out_data : result stream (valid/ready)
//   ap_*                       : control/data bus to the downstream AP
module ap_sequencer
  import ap_pkg::*;
#(
  parameter int unsigned WORD_SIZE      = 8,
  parameter int unsigned CELL_QUANT     = 512,
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                 CLK100MHZ,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           cmd,
  input  logic                 op_direction,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_data,
  output logic [ADDR_W-1:0]    ap_addr,
  output logic [WORD_SIZE-1:0] ap_data,
  output logic                 ap_rst,
  output logic                 ap_op_direction,
  output logic                 ap_mode,
  output logic [2:0]           ap_cmd,
  output logic [1:0]           ap_sel_col,
  output logic                 ap_sel_internal_col,
  output logic                 ap_write_en,
  output logic                 ap_read_en,
  input  logic [WORD_SIZE-1:0] ap_data_out,
  input  logic                 ap_state_irq
);

  localparam int unsigned       WD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(CELL_QUANT - 1);
  localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  seq_state_e           state_q;
  ap_op_e               cmd_q;
  logic                 dir_q;
  logic [ADDR_W-1:0]    row_q;
  logic [WD_W-1:0]      wd_q;

  logic                 busy_q;
  logic                 done_q;
  logic                 timeout_q;
  logic                 out_valid_q;
  logic [WORD_SIZE-1:0] out_data_q;
  logic [ADDR_W-1:0]    ap_addr_q;
  logic [WORD_SIZE-1:0] ap_data_q;
  logic                 ap_rst_q;
  logic                 ap_dir_q;
  logic                 ap_mode_q;
  ap_op_e               ap_cmd_q;
  logic [1:0]           ap_sel_col_q;
  logic                 ap_sel_int_q;
  logic                 ap_write_en_q;
  logic                 ap_read_en_q;

  logic                 irq_rise;
  logic                 last_row;

  ap_irq_edge u_irq_edge (
    .clk_i  (CLK100MHZ),
    .rst_ni (rst_n),
    .irq_i  (ap_state_irq),
    .rise_o (irq_rise)
  );

  assign in_ready = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign last_row = (row_q == LAST_ROW);

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cmd_q         <= OP_OR;
      dir_q         <= 1'b0;
      row_q         <= '0;
      wd_q          <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      ap_addr_q     <= '0;
      ap_data_q     <= '0;
      ap_rst_q      <= 1'b0;
      ap_dir_q      <= 1'b0;
      ap_mode_q     <= 1'b0;
      ap_cmd_q      <= OP_OR;
      ap_sel_col_q  <= COL_A;
      ap_sel_int_q  <= 1'b0;
      ap_write_en_q <= 1'b0;
      ap_read_en_q  <= 1'b0;
    end else begin
      // single-cycle strobes
      done_q        <= 1'b0;
      ap_rst_q      <= 1'b0;
      ap_write_en_q <= 1'b0;
      ap_read_en_q  <= 1'b0;

      if (state_q != S_IDLE && abort) begin
        // a same-cycle input handshake is dropped here
        state_q      <= S_IDLE;
        busy_q       <= 1'b0;
        ap_mode_q    <= 1'b0;
        out_valid_q  <= 1'b0;
        ap_sel_int_q <= 1'b0;
        ap_sel_col_q <= COL_A;
        row_q        <= '0;
        wd_q         <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              cmd_q        <= ap_op_e'(cmd);
              dir_q        <= op_direction;
              timeout_q    <= 1'b0;
              busy_q       <= 1'b1;
              row_q        <= '0;
              ap_rst_q     <= 1'b1;
              ap_sel_int_q <= 1'b0;
              ap_sel_col_q <= COL_A;
              state_q      <= S_CLR0;
            end
          end

          S_CLR0: begin
            ap_rst_q     <= 1'b1;
            ap_sel_int_q <= 1'b1;
            state_q      <= S_CLR1;
          end

          S_CLR1: begin
            ap_sel_int_q <= 1'b0;
            state_q      <= S_LOAD_A;
          end

          S_LOAD_A, S_LOAD_B: begin
            // column select is registered alongside the write strobe so it
            // lags the state by one cycle and always matches the write
            ap_sel_col_q <= (state_q == S_LOAD_A) ? COL_A : COL_B;
            if (in_valid) begin
              ap_write_en_q <= 1'b1;
              ap_addr_q     <= row_q;
              ap_data_q     <= in_data;
              if (last_row) begin
                row_q <= '0;
                if (state_q == S_LOAD_A && cmd_q != OP_NOT) begin
                  state_q <= S_LOAD_B;
                end else begin
                  ap_mode_q <= 1'b1;
                  ap_cmd_q  <= cmd_q;
                  ap_dir_q  <= dir_q;
                  wd_q      <= '0;
                  state_q   <= S_COMPUTE;
                end
              end else begin
                row_q <= row_q + 1'b1;
              end
            end
          end

          S_COMPUTE: begin
            // an edge seen in the first COMPUTE cycle came from an irq that
            // was already high on entry, so it is not taken as completion
            if (irq_rise && wd_q != '0) begin
              ap_mode_q    <= 1'b0;
              ap_read_en_q <= 1'b1;
              ap_addr_q    <= row_q;
              ap_sel_col_q <= COL_C;
              state_q      <= S_RD_REQ;
            end else if (wd_q == WD_LAST) begin
              timeout_q <= 1'b1;
              ap_mode_q <= 1'b0;
              busy_q    <= 1'b0;
              state_q   <= S_IDLE;
            end else begin
              wd_q <= wd_q + 1'b1;
            end
          end

          S_RD_REQ: begin
            state_q <= S_RD_WAIT;
          end

          S_RD_WAIT: begin
            out_data_q  <= ap_data_out;
            out_valid_q <= 1'b1;
            state_q     <= S_RD_HOLD;
          end

          S_RD_HOLD: begin
            if (out_ready) begin
              out_valid_q <= 1'b0;
              if (last_row) begin
                row_q   <= '0;
                done_q  <= 1'b1;
                state_q <= S_FIN;
              end else begin
                row_q        <= row_q + 1'b1;
                ap_read_en_q <= 1'b1;
                ap_addr_q    <= row_q + 1'b1;
                state_q      <= S_RD_REQ;
              end
            end
          end

          S_FIN: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end

          default: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign busy                = busy_q;
  assign done                = done_q;
  assign timeout_err         = timeout_q;
  assign out_valid           = out_valid_q;
  assign out_data            = out_data_q;
  assign ap_addr             = ap_addr_q;
  assign ap_data             = ap_data_q;
  assign ap_rst              = ap_rst_q;
  assign ap_op_direction     = ap_dir_q;
  assign ap_mode             = ap_mode_q;
  assign ap_cmd              = ap_cmd_q;
  assign ap_sel_col          = ap_sel_col_q;
  assign ap_sel_internal_col = ap_sel_int_q;
  assign ap_write_en         = ap_write_en_q;
  assign ap_read_en          = ap_read_en_q;

endmodule

// File: tb/tb_ap_sequencer.sv
// Bench for ap_sequencer with CELL_QUANT=4, TIMEOUT_CYCLES=50 and a
// behavioural AP that raises irq about 10 cycles after ap_mode rises.
module tb_ap_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] cmd;
  logic       op_direction;
  logic       abort;
  logic       busy;
  logic       done;
  logic       timeout_err;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [9:0] ap_addr;
  logic [7:0] ap_data;
  logic       ap_rst;
  logic       ap_op_direction;
  logic       ap_mode;
  logic [2:0] ap_cmd;
  logic [1:0] ap_sel_col;
  logic       ap_sel_internal_col;
  logic       ap_write_en;
  logic       ap_read_en;
  logic [7:0] ap_data_out;
  logic       ap_state_irq;

  ap_sequencer #(
    .WORD_SIZE      (8),
    .CELL_QUANT     (4),
    .ADDR_W         (10),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .CLK100MHZ           (clk),
    .rst_n               (rst_n),
    .start               (start),
    .cmd                 (cmd),
    .op_direction        (op_direction),
    .abort               (abort),
    .busy                (busy),
    .done                (done),
    .timeout_err         (timeout_err),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_data             (in_data),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_data            (out_data),
    .ap_addr             (ap_addr),
    .ap_data             (ap_data),
    .ap_rst              (ap_rst),
    .ap_op_direction     (ap_op_direction),
    .ap_mode             (ap_mode),
    .ap_cmd              (ap_cmd),
    .ap_sel_col          (ap_sel_col),
    .ap_sel_internal_col (ap_sel_internal_col),
    .ap_write_en         (ap_write_en),
    .ap_read_en          (ap_read_en),
    .ap_data_out         (ap_data_out),
    .ap_state_irq        (ap_state_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural AP ----------------
  logic [7:0]  mem_a [4];
  logic [7:0]  mem_b [4];
  logic [7:0]  mem_c [4];
  int unsigned irq_cnt;
  logic        irq_en;
  logic        dir_seen;
  logic [1:0]  clr_mask;

  function automatic logic [7:0] ap_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = a * b;
    case (op)
      3'd0: return a | b;
      3'd1: return a ^ b;
      3'd2: return a & b;
      3'd3: return ~a;
      3'd4: return a + b;
      3'd5: return a - b;
      3'd6: return p[7:0];
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (ap_rst) begin
      clr_mask[ap_sel_internal_col] <= 1'b1;
      for (int i = 0; i < 4; i++) begin
        mem_a[i] <= 8'h00;
        mem_b[i] <= 8'h00;
        mem_c[i] <= 8'h00;
      end
    end
    if (ap_write_en && ap_addr < 10'd4) begin
      if (ap_sel_col == 2'd0) mem_a[ap_addr[1:0]] <= ap_data;
      else if (ap_sel_col == 2'd1) mem_b[ap_addr[1:0]] <= ap_data;
    end
    if (ap_read_en && ap_addr < 10'd4 && ap_sel_col == 2'd2)
      ap_data_out <= mem_c[ap_addr[1:0]];
    if (!ap_mode) begin
      irq_cnt      <= 0;
      ap_state_irq <= 1'b0;
    end else begin
      irq_cnt <= irq_cnt + 1;
      if (irq_en && irq_cnt == 9) begin
        ap_state_irq <= 1'b1;
        dir_seen     <= ap_op_direction;
        for (int i = 0; i < 4; i++) mem_c[i] <= ap_f(ap_cmd, mem_a[i], mem_b[i]);
      end
    end
  end

  // ---------------- scoreboard / monitors ----------------
  logic [7:0]  exp_q [$];
  int unsigned n_out = 0;
  int unsigned done_cnt = 0;
  int unsigned hs_cnt = 0;
  int unsigned mode_cycles = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (ap_mode) mode_cycles++;
      if (in_valid && in_ready) hs_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          check($sformatf("out_data[%0d]", n_out), 32'(out_data), 32'(exp_q.pop_front()));
        end
        n_out++;
      end
    end
  end

  // ---------------- stimulus helpers (entered at a negedge) ----------------
  task automatic do_start(input logic [2:0] c, input logic d);
    cmd = c; op_direction = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] w);
    int unsigned n;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic feed4(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3);
    send(d0); send(d1); send(d2); send(d3);
  endtask

  task automatic expect4(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
    exp_q.push_back(e0); exp_q.push_back(e1); exp_q.push_back(e2); exp_q.push_back(e3);
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n;
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  int unsigned d0;
  int unsigned n;

  initial begin
    rst_n = 1'b0; start = 1'b0; cmd = 3'd0; op_direction = 1'b0; abort = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    irq_en = 1'b1; clr_mask = 2'b00; dir_seen = 1'b0;
    ap_data_out = 8'h00; ap_state_irq = 1'b0; irq_cnt = 0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ap_mode", 32'(ap_mode), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_ap_strobes", {29'd0, ap_rst, ap_write_en, ap_read_en}, 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD vertical, with a start pulse while busy that must be ignored
    d0 = done_cnt; hs_cnt = 0; clr_mask = 2'b00;
    expect4(8'd3, 8'd5, 8'd7, 8'd4);
    do_start(3'd4, 1'b0);
    check("start_to_busy", 32'(busy), 32'd1);
    cmd = 3'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    feed4(8'd1, 8'd2, 8'd3, 8'd250);
    feed4(8'd2, 8'd3, 8'd4, 8'd10);
    in_valid = 1'b0;
    wait_idle("add");
    check("add_done_once", done_cnt - d0, 32'd1);
    check("add_beats", hs_cnt, 32'd8);
    check("add_banks_cleared", 32'(clr_mask), 32'd3);
    check("add_dir", 32'(dir_seen), 32'd0);
    check("add_sb_empty", exp_q.size(), 32'd0);

    // NOT: only column A is loaded
    d0 = done_cnt; hs_cnt = 0;
    expect4(8'd255, 8'd0, 8'd240, 8'd85);
    do_start(3'd3, 1'b0);
    feed4(8'd0, 8'd255, 8'd15, 8'd170);
    in_data = 8'h77;
    for (int i = 0; i < 3; i++) begin
      check("not_in_ready_low", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("not_beats", hs_cnt, 32'd4);
    wait_idle("not");
    check("not_done_once", done_cnt - d0, 32'd1);

    // XOR horizontal with backpressure on the second result
    d0 = done_cnt; n_out = 0;
    expect4(8'hF0, 8'hFC, 8'hFF, 8'h26);
    do_start(3'd1, 1'b1);
    feed4(8'h0F, 8'hF0, 8'hAA, 8'h12);
    feed4(8'hFF, 8'h0C, 8'h55, 8'h34);
    in_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(out_valid && n_out == 1) && n < 300);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_data", 32'(out_data), 32'hFC);
    end
    out_ready = 1'b1;
    @(negedge clk);
    wait_idle("xor");
    check("xor_done_once", done_cnt - d0, 32'd1);
    check("xor_dir", 32'(dir_seen), 32'd1);
    check("xor_sb_empty", exp_q.size(), 32'd0);

    // watchdog: AP never raises irq
    d0 = done_cnt; irq_en = 1'b0; mode_cycles = 0;
    do_start(3'd2, 1'b0);
    feed4(8'd1, 8'd2, 8'd3, 8'd4);
    feed4(8'd5, 8'd6, 8'd7, 8'd8);
    in_valid = 1'b0;
    wait_idle("tmo");
    check("tmo_err", 32'(timeout_err), 32'd1);
    check("tmo_ap_mode", 32'(ap_mode), 32'd0);
    check("tmo_mode_cycles", mode_cycles, 32'd50);
    check("tmo_no_done", done_cnt - d0, 32'd0);
    irq_en = 1'b1;

    // abort in LOAD_B after two beats, then a fresh job
    d0 = done_cnt;
    do_start(3'd0, 1'b0);
    check("start_clears_tmo", 32'(timeout_err), 32'd0);
    feed4(8'hEE, 8'hEE, 8'hEE, 8'hEE);
    send(8'hDD); send(8'hDD);
    in_data = 8'h99; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_write_en", 32'(ap_write_en), 32'd0);
    check("abort_ap_mode", 32'(ap_mode), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("abort_still_idle", 32'(busy), 32'd0);
    expect4(8'h03, 8'h30, 8'h88, 8'h00);
    do_start(3'd0, 1'b0);
    feed4(8'h01, 8'h10, 8'h80, 8'h00);
    feed4(8'h02, 8'h20, 8'h08, 8'h00);
    in_valid = 1'b0;
    wait_idle("restart");
    check("restart_done_once", done_cnt - d0, 32'd1);
    check("restart_sb_empty", exp_q.size(), 32'd0);

    // async reset in mid-COMPUTE
    d0 = done_cnt;
    do_start(3'd5, 1'b0);
    feed4(8'd9, 8'd9, 8'd9, 8'd9);
    feed4(8'd1, 8'd1, 8'd1, 8'd1);
    in_valid = 1'b0;
    n = 0;
    while (!ap_mode && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("pre_rst_ap_mode", 32'(ap_mode), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ap_mode", 32'(ap_mode), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_no_done", done_cnt - d0, 32'd0);
    check("final_sb_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1);
  end

endmodule
